// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - RV32I decode stage: register file, immediates, control decode, ID/EX handshake register
// Optional feature macro: ID_WB_BYPASS_EN (write-back to read-port bypass)
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_regwrite,
    output logic            ex_memtoreg,
    output logic            ex_alusrc,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic [3:0]      ex_aluop,
    output logic            ex_illegal
);
    localparam int         AW     = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam logic [5:0] RF_LIM = 6'(RF_DEPTH);

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic       jump;
        logic [3:0] aluop;
        logic       illegal;
    } ctrl_t;

    logic [XLEN-1:0] regs [RF_DEPTH];

    ctrl_t           d_ctrl;
    ctrl_t           ex_ctrl;
    logic            use_rs1, use_rs2, use_rd;
    logic [4:0]      d_rs1, d_rs2, d_rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] d_imm;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            load_use, wb_hazard, hazard;

    wire [6:0] opcode = if_instr[6:0];
    wire [4:0] f_rs1  = if_instr[19:15];
    wire [4:0] f_rs2  = if_instr[24:20];
    wire [4:0] f_rd   = if_instr[11:7];

    // Main control decode and immediate generation for the presented instruction
    always_comb begin
        d_ctrl  = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        imm32   = '0;
        case (opcode)
            7'b0110011: begin
                d_ctrl.regwrite = 1'b1; d_ctrl.aluop = 4'b0010;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
            end
            7'b0010011: begin
                d_ctrl.regwrite = 1'b1; d_ctrl.alusrc = 1'b1; d_ctrl.aluop = 4'b0011;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            7'b0000011: begin
                d_ctrl.memread = 1'b1; d_ctrl.regwrite = 1'b1; d_ctrl.memtoreg = 1'b1;
                d_ctrl.alusrc = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            7'b0100011: begin
                d_ctrl.memwrite = 1'b1; d_ctrl.alusrc = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            7'b1100011: begin
                d_ctrl.branch = 1'b1; d_ctrl.aluop = 4'b0110;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                         if_instr[30:25], if_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                d_ctrl.jump = 1'b1; d_ctrl.regwrite = 1'b1; d_ctrl.alusrc = 1'b1;
                d_ctrl.aluop = 4'b1001;
                use_rd = 1'b1;
                imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                         if_instr[20], if_instr[30:21], 1'b0};
            end
            7'b1100111: begin
                d_ctrl.jump = 1'b1; d_ctrl.regwrite = 1'b1; d_ctrl.alusrc = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            7'b0110111: begin
                d_ctrl.regwrite = 1'b1; d_ctrl.alusrc = 1'b1; d_ctrl.aluop = 4'b1000;
                use_rd = 1'b1;
                imm32 = {if_instr[31:12], 12'b0};
            end
            7'b0010111: begin
                d_ctrl.regwrite = 1'b1; d_ctrl.alusrc = 1'b1;
                use_rd = 1'b1;
                imm32 = {if_instr[31:12], 12'b0};
            end
            default: d_ctrl.illegal = 1'b1;
        endcase

        d_rs1 = use_rs1 ? f_rs1 : 5'd0;
        d_rs2 = use_rs2 ? f_rs2 : 5'd0;
        d_rd  = use_rd  ? f_rd  : 5'd0;

        // Registers beyond the implemented file (RV32E) make the instruction illegal
        if ({1'b0, d_rs1} >= RF_LIM || {1'b0, d_rs2} >= RF_LIM || {1'b0, d_rd} >= RF_LIM)
            d_ctrl.illegal = 1'b1;

        if (d_ctrl.illegal) begin
            d_ctrl         = '0;
            d_ctrl.illegal = 1'b1;
            imm32          = '0;
        end
        if (d_rd == 5'd0)
            d_ctrl.regwrite = 1'b0;

        d_imm = XLEN'($signed(imm32));
    end

    // Register file read ports, optionally bypassing same-cycle write-back
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (d_rs1 != 5'd0 && {1'b0, d_rs1} < RF_LIM)
            rs1_data = regs[d_rs1[AW-1:0]];
        if (d_rs2 != 5'd0 && {1'b0, d_rs2} < RF_LIM)
            rs2_data = regs[d_rs2[AW-1:0]];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_addr != 5'd0 && wb_addr == d_rs1)
            rs1_data = wb_data;
        if (wb_en && wb_addr != 5'd0 && wb_addr == d_rs2)
            rs2_data = wb_data;
`endif
    end

    // Hazard detection: load-use, plus same-cycle write-back when there is no bypass
    always_comb begin
        load_use = ex_valid && ex_ctrl.memread && ex_rd != 5'd0 &&
                   ((use_rs1 && ex_rd == f_rs1) || (use_rs2 && ex_rd == f_rs2));
`ifdef ID_WB_BYPASS_EN
        wb_hazard = 1'b0;
`else
        wb_hazard = wb_en && wb_addr != 5'd0 &&
                    ((use_rs1 && wb_addr == f_rs1) || (use_rs2 && wb_addr == f_rs2));
`endif
        hazard   = load_use || wb_hazard;
        id_ready = !rst && !flush && (!ex_valid || ex_ready) && !hazard;
    end

    // Register file write; x0 and out-of-range addresses are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++)
                regs[i] <= '0;
        end else if (wb_en && wb_addr != 5'd0 && {1'b0, wb_addr} < RF_LIM) begin
            regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    // ID/EX boundary: reset, flush, EX stall hold, hazard bubble, load, drain
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_valid && !ex_ready) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (if_valid && id_ready) begin
            ex_valid    <= 1'b1;
            ex_ctrl     <= d_ctrl;
            ex_pc       <= if_pc;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= d_imm;
            ex_rs1      <= d_rs1;
            ex_rs2      <= d_rs2;
            ex_rd       <= d_rd;
            ex_funct3   <= if_instr[14:12];
            ex_funct7   <= if_instr[31:25];
        end else begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_memread  = ex_ctrl.memread;
    assign ex_memwrite = ex_ctrl.memwrite;
    assign ex_regwrite = ex_ctrl.regwrite;
    assign ex_memtoreg = ex_ctrl.memtoreg;
    assign ex_alusrc   = ex_ctrl.alusrc;
    assign ex_branch   = ex_ctrl.branch;
    assign ex_jump     = ex_ctrl.jump;
    assign ex_aluop    = ex_ctrl.aluop;
    assign ex_illegal  = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed-vector bench for id_stage_pipe (RF_DEPTH 32 and 16 instances)
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] if_pc = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_ready = 1'b1;

    logic        id_ready, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_alusrc, ex_branch, ex_jump;
    logic [3:0]  ex_aluop;
    logic        ex_illegal;

    logic        e_id_ready, e_valid;
    logic [31:0] e_pc, e_rs1_data, e_rs2_data, e_imm;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]  e_funct3;
    logic [6:0]  e_funct7;
    logic        e_memread, e_memwrite, e_regwrite, e_memtoreg, e_alusrc, e_branch, e_jump;
    logic [3:0]  e_aluop;
    logic        e_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .RF_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_aluop(ex_aluop),
        .ex_illegal(ex_illegal)
    );

    id_stage_pipe #(.XLEN(32), .RF_DEPTH(16)) dut_e (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(e_id_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_ready(ex_ready), .ex_valid(e_valid), .ex_pc(e_pc), .ex_rs1_data(e_rs1_data),
        .ex_rs2_data(e_rs2_data), .ex_imm(e_imm), .ex_rs1(e_rs1), .ex_rs2(e_rs2), .ex_rd(e_rd),
        .ex_funct3(e_funct3), .ex_funct7(e_funct7), .ex_memread(e_memread),
        .ex_memwrite(e_memwrite), .ex_regwrite(e_regwrite), .ex_memtoreg(e_memtoreg),
        .ex_alusrc(e_alusrc), .ex_branch(e_branch), .ex_jump(e_jump), .ex_aluop(e_aluop),
        .ex_illegal(e_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_id_ready", id_ready, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_ex_regwrite", ex_regwrite, 0);
        rst = 1'b0;
        #1;
        chk("idle_id_ready", id_ready, 1);

        // ADDI x1,x0,5
        present(32'h0050_0093, 32'h100);
        tick();
        chk("addi_valid", ex_valid, 1);
        chk("addi_imm", ex_imm, 5);
        chk("addi_aluop", ex_aluop, 4'b0011);
        chk("addi_regwrite", ex_regwrite, 1);
        chk("addi_rd", ex_rd, 1);
        chk("addi_pc", ex_pc, 32'h100);
        chk("addi_alusrc", ex_alusrc, 1);

        // write x1=7, then attempt a write to x0
        if_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
        tick();
        chk("drain_valid", ex_valid, 0);
        wb_addr = 5'd0; wb_data = 32'h55;
        tick();
        wb_en = 1'b0;

        // LW x2,0(x1)
        present(32'h0000_A103, 32'h104);
        tick();
        chk("lw_memread", ex_memread, 1);
        chk("lw_memtoreg", ex_memtoreg, 1);
        chk("lw_rd", ex_rd, 2);
        chk("lw_rs1_data", ex_rs1_data, 7);
        chk("lw_aluop", ex_aluop, 4'b0000);

        // ADD x3,x2,x1 -> one load-use bubble
        present(32'h0011_01B3, 32'h108);
        chk("lu_id_ready", id_ready, 0);
        tick();
        chk("lu_bubble", ex_valid, 0);
        chk("lu_ready_after", id_ready, 1);
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_rs1", ex_rs1, 2);
        chk("add_rs2", ex_rs2, 1);
        chk("add_rs2_data", ex_rs2_data, 7);
        chk("add_aluop", ex_aluop, 4'b0010);
        chk("add_alusrc", ex_alusrc, 0);

        // ADD x6,x5,x0 with same-cycle write-back of x5
        present(32'h0002_8333, 32'h10C);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
`ifdef ID_WB_BYPASS_EN
        chk("byp_id_ready", id_ready, 1);
        tick();
        wb_en = 1'b0;
`else
        chk("wbh_id_ready", id_ready, 0);
        tick();
        wb_en = 1'b0;
        chk("wbh_bubble", ex_valid, 0);
        tick();
`endif
        chk("wb_rs1_data", ex_rs1_data, 32'hDEAD_BEEF);
        chk("wb_rd", ex_rd, 6);
        chk("wb_valid", ex_valid, 1);

        // EX stall for three cycles with LUI x7,0x12345 waiting
        present(32'h1234_53B7, 32'h110);
        ex_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_id_ready", id_ready, 0);
            tick();
            chk("stall_valid", ex_valid, 1);
            chk("stall_rd", ex_rd, 6);
            chk("stall_pc", ex_pc, 32'h10C);
        end
        ex_ready = 1'b1;
        #1;
        chk("release_id_ready", id_ready, 1);
        tick();
        chk("lui_rd", ex_rd, 7);
        chk("lui_imm", ex_imm, 32'h1234_5000);
        chk("lui_aluop", ex_aluop, 4'b1000);

        // flush with JAL x1,-4 presented: not accepted, then accepted
        present(32'hFFDF_F0EF, 32'h114);
        flush = 1'b1;
        #1;
        chk("flush_id_ready", id_ready, 0);
        tick();
        chk("flush_valid", ex_valid, 0);
        flush = 1'b0;
        tick();
        chk("jal_valid", ex_valid, 1);
        chk("jal_imm", ex_imm, 32'hFFFF_FFFC);
        chk("jal_jump", ex_jump, 1);
        chk("jal_aluop", ex_aluop, 4'b1001);
        chk("jal_pc", ex_pc, 32'h114);

        // ADD x8,x0,x0: x0 reads zero despite the earlier write attempt
        present(32'h0000_0433, 32'h118);
        tick();
        chk("x0_rs1_data", ex_rs1_data, 0);
        chk("x0_rs2_data", ex_rs2_data, 0);

        // ADDI x0,x0,1: regwrite suppressed for rd=0
        present(32'h0010_0013, 32'h11C);
        tick();
        chk("rd0_regwrite", ex_regwrite, 0);
        chk("rd0_imm", ex_imm, 1);

        // SW x2,-8(x1)
        present(32'hFE20_AC23, 32'h120);
        tick();
        chk("sw_imm", ex_imm, 32'hFFFF_FFF8);
        chk("sw_memwrite", ex_memwrite, 1);
        chk("sw_rd", ex_rd, 0);
        chk("sw_rs1_data", ex_rs1_data, 7);

        // unsupported opcode
        present(32'hFFFF_FFFF, 32'h124);
        tick();
        chk("ill_flag", ex_illegal, 1);
        chk("ill_valid", ex_valid, 1);
        chk("ill_imm", ex_imm, 0);
        chk("ill_regwrite", ex_regwrite, 0);

        // ADD x17,x1,x2: legal on 32 registers, illegal on 16
        present(32'h0020_88B3, 32'h128);
        tick();
        chk("x17_illegal_32", ex_illegal, 0);
        chk("x17_regwrite_32", ex_regwrite, 1);
        chk("x17_illegal_16", e_illegal, 1);
        chk("x17_regwrite_16", e_regwrite, 0);

        // reset while EX is stalled discards the held entry
        present(32'h0050_0093, 32'h12C);
        ex_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_stall_valid", ex_valid, 0);
        chk("rst_stall_rd", ex_rd, 0);
        rst = 1'b0;
        ex_ready = 1'b1;
        if_valid = 1'b0;
        tick();
        chk("post_rst_valid", ex_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
